// File: rtl/mem_pkg.sv
// Shared constants for the byte-addressed memory controller:
// default geometry and the request/response FSM state encoding.
package mem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int BYTES_DEF  = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

endpackage

// File: rtl/byte_ram.sv
// Byte-wide storage array with BYTES write lanes and BYTES read lanes.
// Lane i targets (addr + i) modulo the array depth.
module byte_ram
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYTES  = BYTES_DEF
) (
    input  logic                  clk,
    input  logic [BYTES-1:0]      we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [8*BYTES-1:0]    wdata,
    output logic [8*BYTES-1:0]    rdata
);

    logic [7:0] mem_q [2**ADDR_W];

    // Lane index arithmetic is ADDR_W wide, so the top wraps to 0.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (we[i]) begin
                mem_q[addr + ADDR_W'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < BYTES; i++) begin
            rdata[8*i +: 8] = mem_q[addr + ADDR_W'(i)];
        end
    end

endmodule

// File: rtl/byte_mem_ctrl.sv
// Single-outstanding valid/ready controller in front of byte_ram.
// Reads and writes complete at the accepting edge; response follows.
module byte_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int BYTES       = BYTES_DEF,
    parameter bit ALIGN_CHECK = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [8*BYTES-1:0]    req_wdata,
    input  logic [BYTES-1:0]      req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*BYTES-1:0]    rsp_rdata,
    output logic                  rsp_err
);

    logic [0:0]           state_q, state_d;
    logic [8*BYTES-1:0]   rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 misalign;
    logic [BYTES-1:0]     ram_we;
    logic [8*BYTES-1:0]   ram_rdata;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign accept   = req_valid && req_ready;
    assign misalign = ALIGN_CHECK && ((32'(req_addr) % BYTES) != 0);
    assign ram_we   = {BYTES{accept && req_write && !misalign}} & req_be;

    byte_ram #(
        .ADDR_W (ADDR_W),
        .BYTES  (BYTES)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (req_addr),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (1'b1)
            (state_q == ST_IDLE): begin
                if (accept) begin
                    state_d = ST_RESP;
                    err_d   = misalign;
                    rdata_d = (req_write || misalign) ? '0 : ram_rdata;
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
